// File: rtl/proc_trace_pkg.sv
// Shared types and constants for the processor trace checker.
package proc_trace_pkg;

   localparam int TRACE_PIPE = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      PASS = 2'd2,
      FAIL = 2'd3
   } state_t;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
      logic        dcare;
   } exp_entry_t;

endpackage

// File: rtl/proc_trace_checker_delay_pipe.sv
// Fixed-depth shift register carrying {valid, addr, inst} from the fetch
// stage down to the writeback stage. Only the valid bits are cleared; the
// payload is don't-care whenever its valid bit is low.
module trace_delay_pipe #(
   parameter int STAGES = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        clr,
   input  logic        in_valid,
   input  logic [31:0] in_addr,
   input  logic [31:0] in_inst,
   output logic        out_valid,
   output logic [31:0] out_addr,
   output logic [31:0] out_inst
);

   logic [STAGES-1:0] vld_q;
   logic [31:0]       addr_q [STAGES];
   logic [31:0]       inst_q [STAGES];

   // Valid bits shift every cycle; reset or clear empties the pipe.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         vld_q <= '0;
      end else begin
         vld_q[0] <= in_valid;
         for (int i = 1; i < STAGES; i++) vld_q[i] <= vld_q[i-1];
      end
   end

   // Payload shifts alongside the valid bits.
   always_ff @(posedge clk) begin
      addr_q[0] <= in_addr;
      inst_q[0] <= in_inst;
      for (int i = 1; i < STAGES; i++) begin
         addr_q[i] <= addr_q[i-1];
         inst_q[i] <= inst_q[i-1];
      end
   end

   assign out_valid = vld_q[STAGES-1];
   assign out_addr  = addr_q[STAGES-1];
   assign out_inst  = inst_q[STAGES-1];

endmodule

// File: rtl/proc_trace_checker.sv
// Compares the retired processor stream against a table of expected
// writeback PC/data pairs and reports pass or the first mismatch.
//
//   state | meaning
//   IDLE  | table loadable, waiting for start
//   RUN   | pushing fetch trace, comparing W-stage entries
//   PASS  | all n entries matched; start reruns
//   FAIL  | first mismatch latched in fail_*; start reruns
module proc_trace_checker
   import proc_trace_pkg::*;
#(
   parameter int DEPTH = 64,
   parameter int IDXW  = $clog2(DEPTH),
   parameter int PIPE  = TRACE_PIPE
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            load_val,
   input  logic [IDXW-1:0] load_idx,
   input  logic [31:0]     load_addr,
   input  logic [31:0]     load_data,
   input  logic            load_dcare,
   input  logic            start,
   input  logic [IDXW:0]   num_entries,
   input  logic [31:0]     trace_addr,
   input  logic [31:0]     trace_inst,
   input  logic [31:0]     trace_data,
   output logic            done,
   output logic            pass,
   output logic [IDXW-1:0] fail_idx,
   output logic [31:0]     fail_addr,
   output logic [31:0]     fail_data,
   output logic [31:0]     fail_inst,
   output logic [IDXW:0]   check_count
);

   localparam logic [IDXW:0] DEPTH_N = (IDXW+1)'(DEPTH);
   localparam logic [IDXW:0] ONE     = (IDXW+1)'(1);

   state_t        state;
   exp_entry_t    tbl [DEPTH];
   exp_entry_t    exp_cur;
   logic [IDXW:0] index;
   logic [IDXW:0] n_q;
   logic [IDXW:0] n_clamp;
   logic [IDXW:0] index_inc;
   logic          start_acc;
   logic          w_valid;
   logic [31:0]   w_addr;
   logic [31:0]   w_inst;
   logic          w_match;

   assign start_acc = start && (state != RUN);
   assign n_clamp   = (num_entries > DEPTH_N) ? DEPTH_N : num_entries;
   assign index_inc = index + ONE;
   // index only reaches DEPTH once the run is finishing, so no compare
   // ever uses the wrapped read.
   assign exp_cur   = tbl[index[IDXW-1:0]];
   // An unknown compare result falls into the mismatch branch below.
   assign w_match   = (w_addr == exp_cur.addr) &&
                      (exp_cur.dcare || (trace_data == exp_cur.data));

   trace_delay_pipe #(.STAGES(PIPE)) u_pipe (
      .clk       (clk),
      .rst       (rst),
      .clr       (start_acc),
      .in_valid  (state == RUN),
      .in_addr   (trace_addr),
      .in_inst   (trace_inst),
      .out_valid (w_valid),
      .out_addr  (w_addr),
      .out_inst  (w_inst)
   );

   // Expected-trace table; writable only while idle and deliberately not reset.
   always_ff @(posedge clk) begin
      if (load_val && (state == IDLE))
         tbl[load_idx] <= '{addr: load_addr, data: load_data, dcare: load_dcare};
   end

   // Sequencing, compare bookkeeping and registered verdict outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         done        <= 1'b0;
         pass        <= 1'b0;
         fail_idx    <= '0;
         fail_addr   <= '0;
         fail_data   <= '0;
         fail_inst   <= '0;
         check_count <= '0;
         index       <= '0;
         n_q         <= '0;
      end else if (start_acc) begin
         state       <= RUN;
         done        <= 1'b0;
         pass        <= 1'b0;
         fail_idx    <= '0;
         fail_addr   <= '0;
         fail_data   <= '0;
         fail_inst   <= '0;
         check_count <= '0;
         index       <= '0;
         n_q         <= n_clamp;
      end else if (state == RUN) begin
         if (index == n_q) begin
            state <= PASS;
            done  <= 1'b1;
            pass  <= 1'b1;
         end else if (w_valid) begin
            check_count <= check_count + ONE;
            if (w_match) begin
               index <= index_inc;
               if (index_inc == n_q) begin
                  state <= PASS;
                  done  <= 1'b1;
                  pass  <= 1'b1;
               end
            end else begin
               state     <= FAIL;
               done      <= 1'b1;
               fail_idx  <= index[IDXW-1:0];
               fail_addr <= w_addr;
               fail_data <= trace_data;
               fail_inst <= w_inst;
            end
         end
      end
   end

endmodule

// File: tb/tb_proc_trace_checker.sv
// Scoreboard bench for proc_trace_checker: a reference model predicts each
// run's verdict and completion cycle; the prediction is queued at start and
// popped when done rises.
module tb_proc_trace_checker;

   localparam int D    = 8;
   localparam int IW   = 3;
   localparam int NOBS = 16;

   typedef struct {
      logic        pass;
      logic [31:0] fidx;
      logic [31:0] faddr;
      logic [31:0] fdata;
      logic [31:0] finst;
      logic [31:0] cc;
      int          cyc;
   } verdict_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          load_val = 1'b0;
   logic [IW-1:0] load_idx = '0;
   logic [31:0]   load_addr = '0;
   logic [31:0]   load_data = '0;
   logic          load_dcare = 1'b0;
   logic          start = 1'b0;
   logic [IW:0]   num_entries = '0;
   logic [31:0]   trace_addr = '0;
   logic [31:0]   trace_inst = '0;
   logic [31:0]   trace_data = '0;
   logic          done, pass;
   logic [IW-1:0] fail_idx;
   logic [31:0]   fail_addr, fail_data, fail_inst;
   logic [IW:0]   check_count;

   int errors = 0;
   int checks = 0;

   logic [31:0] tbl_addr [D];
   logic [31:0] tbl_data [D];
   logic        tbl_dc   [D];
   logic [31:0] obs_addr [NOBS];
   logic [31:0] obs_data [NOBS];
   verdict_t    sb_q [$];

   proc_trace_checker #(.DEPTH(D), .IDXW(IW), .PIPE(4)) dut (
      .clk(clk), .rst(rst),
      .load_val(load_val), .load_idx(load_idx), .load_addr(load_addr),
      .load_data(load_data), .load_dcare(load_dcare),
      .start(start), .num_entries(num_entries),
      .trace_addr(trace_addr), .trace_inst(trace_inst), .trace_data(trace_data),
      .done(done), .pass(pass), .fail_idx(fail_idx), .fail_addr(fail_addr),
      .fail_data(fail_data), .fail_inst(fail_inst), .check_count(check_count)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] inst_of(int k);
      return 32'h1300_0000 | 32'(k);
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic load_entry(input int idx, input logic [31:0] a, input logic [31:0] d,
                             input logic dc);
      @(negedge clk);
      load_val = 1'b1; load_idx = IW'(idx); load_addr = a; load_data = d; load_dcare = dc;
      tbl_addr[idx] = a; tbl_data[idx] = d; tbl_dc[idx] = dc;
      @(negedge clk);
      load_val = 1'b0;
   endtask

   // Matching stream for the current table, repeated past the table end.
   task automatic golden_stream();
      for (int k = 0; k < NOBS; k++) begin
         obs_addr[k] = tbl_addr[k % D];
         obs_data[k] = tbl_dc[k % D] ? 32'hDEAD_0000 | 32'(k) : tbl_data[k % D];
      end
   endtask

   // Optionally loads one entry in the start cycle (lw_start, model updated
   // as the DUT is idle) or one entry during RUN (lw_run, model untouched).
   task automatic run(input int n, input bit first_chk,
                      input bit lw_start, input bit lw_run, input int lw_idx,
                      input logic [31:0] lw_addr, input logic [31:0] lw_data, input logic lw_dc);
      verdict_t v;
      verdict_t got;
      int ne;
      bit seen;
      if (lw_start) begin
         tbl_addr[lw_idx] = lw_addr; tbl_data[lw_idx] = lw_data; tbl_dc[lw_idx] = lw_dc;
      end
      ne = (n > D) ? D : n;
      v = '{pass: 1'b1, fidx: 0, faddr: 0, fdata: 0, finst: 0, cc: 0,
            cyc: (ne == 0) ? 2 : 5 + ne};
      for (int k = 0; k < ne; k++) begin
         v.cc++;
         if (!(obs_addr[k] == tbl_addr[k] && (tbl_dc[k] || obs_data[k] == tbl_data[k]))) begin
            v.pass = 1'b0; v.fidx = 32'(k); v.faddr = obs_addr[k];
            v.fdata = obs_data[k]; v.finst = inst_of(k); v.cyc = 6 + k;
            break;
         end
      end
      sb_q.push_back(v);

      @(negedge clk);
      start = 1'b1; num_entries = (IW+1)'(n);
      if (lw_start) begin
         load_val = 1'b1; load_idx = IW'(lw_idx); load_addr = lw_addr;
         load_data = lw_data; load_dcare = lw_dc;
      end
      seen = 1'b0;
      for (int c = 1; c < 60 && !seen; c++) begin
         @(negedge clk);
         start = 1'b0;
         load_val = 1'b0;
         if (lw_run && c == 2) begin
            load_val = 1'b1; load_idx = IW'(lw_idx); load_addr = lw_addr;
            load_data = lw_data; load_dcare = lw_dc;
         end
         trace_addr = (c - 1 < NOBS) ? obs_addr[c-1] : 32'h0;
         trace_inst = inst_of(c - 1);
         trace_data = (c >= 5 && c - 5 < NOBS) ? obs_data[c-5] : 32'h0;
         if (first_chk && c == 5) chk("cc_before_first_compare", 32'(check_count), 0);
         if (first_chk && c == 6) chk("cc_after_first_compare", 32'(check_count), 1);
         if (done) begin
            seen = 1'b1;
            got = sb_q.pop_front();
            chk("done_cycle", 32'(c), 32'(got.cyc));
            chk("pass", 32'(pass), 32'(got.pass));
            chk("check_count", 32'(check_count), got.cc);
            chk("fail_idx", 32'(fail_idx), got.fidx);
            chk("fail_addr", fail_addr, got.faddr);
            chk("fail_data", fail_data, got.fdata);
            chk("fail_inst", fail_inst, got.finst);
         end
      end
      load_val = 1'b0;
      if (!seen) begin
         chk("done_within_budget", 32'(done), 1);
         void'(sb_q.pop_front());
      end
      @(negedge clk);
      chk("done_held", 32'(done), 1);
   endtask

   initial begin
      for (int k = 0; k < D; k++) begin
         tbl_addr[k] = 32'h200 + 32'(4 * k); tbl_data[k] = 32'h100 + 32'(k); tbl_dc[k] = 1'b0;
      end
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("rst_done", 32'(done), 0);
      chk("rst_pass", 32'(pass), 0);
      chk("rst_check_count", 32'(check_count), 0);
      chk("rst_fail_addr", fail_addr, 0);

      // Fill the whole table, then overwrite the first three per the plan;
      // entry 2 is written in the same cycle as start.
      for (int k = 0; k < D; k++) load_entry(k, tbl_addr[k], tbl_data[k], 1'b0);
      load_entry(0, 32'h200, 32'h0, 1'b1);
      load_entry(1, 32'h204, 32'h5, 1'b0);
      tbl_addr[2] = 32'h0; tbl_data[2] = 32'h0;
      golden_stream();
      obs_addr[2] = 32'h208; obs_data[2] = 32'hA;
      run(3, 1'b1, 1'b1, 1'b0, 2, 32'h208, 32'hA, 1'b0);

      // Data mismatch on entry 1.
      golden_stream();
      obs_data[1] = 32'h6;
      run(3, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0);

      // PC mismatch on entry 2; its data value is irrelevant.
      golden_stream();
      obs_addr[2] = 32'h20C; obs_data[2] = 32'h123;
      run(3, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0);

      // Zero-length run.
      golden_stream();
      run(0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0);

      // Over-range count is clamped to the table depth.
      run(15, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0);

      // Reset two cycles into a run, then rerun with the retained table.
      @(negedge clk);
      start = 1'b1; num_entries = 4'd3;
      @(negedge clk);
      start = 1'b0; trace_addr = obs_addr[0];
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("midrun_rst_done", 32'(done), 0);
      chk("midrun_rst_pass", 32'(pass), 0);
      chk("midrun_rst_check_count", 32'(check_count), 0);
      chk("midrun_rst_fail_idx", 32'(fail_idx), 0);
      chk("midrun_rst_fail_inst", fail_inst, 0);
      rst = 1'b0;
      run(3, 1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b0);

      // Load during RUN is ignored; then rerun straight from PASS.
      run(3, 1'b0, 1'b0, 1'b1, 1, 32'h204, 32'hFFFF, 1'b0);
      run(3, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
